// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll sequencer.
`timescale 1ns/1ps
package dice_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPIN   = 3'd1,
      SLOW   = 3'd2,
      SETTLE = 3'd3,
      HOLD   = 3'd4
   } roll_state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [2:0]  DICE_MIN  = 3'd1;
   localparam logic [2:0]  DICE_MAX  = 3'd6;

   // One right shift of the Galois register; the bit shifted out selects the tap mask.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/dice_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed is promoted to 1 so it can never lock up.
`timescale 1ns/1ps
module dice_lfsr
   import dice_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
)(
   input  logic        Clock,
   input  logic        nReset,
   output logic [15:0] State
);

   localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] r_state;

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) r_state <= SEED_NZ;
      else         r_state <= lfsr_next(r_state);
   end

   assign State = r_state;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: fast spin while the button is held, decelerating steps, capture, hold-off.
//   state  | meaning
//   IDLE   | waiting for a Roll rising edge
//   SPIN   | one step per cycle, at least SPIN_MIN, extended while Roll is held
//   SLOW   | SLOW_STEPS steps, step i preceded by a 2^(i+1)-cycle gap
//   SETTLE | capture DiceValue into Result, flag illegal faces
//   HOLD   | HOLDOFF cycles with Roll ignored
`timescale 1ns/1ps
module dice_roll_ctrl
   import dice_pkg::*;
#(
   parameter int unsigned SPIN_MIN   = 16,
   parameter int unsigned SLOW_STEPS = 4,
   parameter int unsigned HOLDOFF    = 64,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
)(
   input  logic       Clock,
   input  logic       nReset,
   input  logic       Roll,
   input  logic [2:0] DiceValue,
   output logic [1:0] Ran,
   output logic       Step,
   output logic       Busy,
   output logic [2:0] Result,
   output logic       ResultValid,
   output logic       Error
);

   localparam logic [15:0] SPIN_TC  = 16'(SPIN_MIN);
   localparam logic [15:0] HOLD_TC  = 16'(HOLDOFF);
   localparam logic [2:0]  LAST_IDX = 3'(SLOW_STEPS - 1);

   roll_state_t r_state, w_state_nxt;
   logic        r_s0, r_s1, r_prev;
   logic        w_rise;
   logic [15:0] r_cnt, w_cnt_nxt;
   logic [9:0]  r_gap, w_gap_nxt;
   logic [2:0]  r_idx, w_idx_nxt;
   logic        r_step, w_step_nxt;
   logic        w_capture;
   logic [2:0]  r_result;
   logic        r_valid, r_error;
   logic [15:0] w_lfsr;
   logic        w_lfsr_unused;

   dice_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .Clock  (Clock),
      .nReset (nReset),
      .State  (w_lfsr)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_s0   <= 1'b0;
         r_s1   <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_s0   <= Roll;
         r_s1   <= r_s0;
         r_prev <= r_s1;
      end
   end

   assign w_rise = r_s1 & ~r_prev;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_idx_nxt   = r_idx;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt = SPIN;
               w_cnt_nxt   = 16'd0;
            end
         end
         SPIN: begin
            // Counting this cycle's step lets the exit land on exactly SPIN_MIN steps.
            if (r_cnt != SPIN_TC) w_cnt_nxt = r_cnt + 16'd1;
            if ((w_cnt_nxt == SPIN_TC) && !r_s1) begin
               w_state_nxt = SLOW;
               w_gap_nxt   = 10'd2;
               w_idx_nxt   = 3'd0;
            end
         end
         SLOW: begin
            if (r_gap != 10'd0) begin
               w_gap_nxt = r_gap - 10'd1;
            end else if (r_idx == LAST_IDX) begin
               w_state_nxt = SETTLE;
            end else begin
               w_idx_nxt = r_idx + 3'd1;
               w_gap_nxt = 10'd4 << r_idx;
            end
         end
         SETTLE: begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
            w_cnt_nxt   = 16'd0;
         end
         HOLD: begin
            w_cnt_nxt = r_cnt + 16'd1;
            if (w_cnt_nxt == HOLD_TC) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // Step is looked ahead one cycle so the flop output lines up with the state it belongs to.
      w_step_nxt = (w_state_nxt == SPIN) ||
                   ((w_state_nxt == SLOW) && (w_gap_nxt == 10'd0));
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= IDLE;
         r_cnt   <= 16'd0;
         r_gap   <= 10'd0;
         r_idx   <= 3'd0;
         r_step  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gap   <= w_gap_nxt;
         r_idx   <= w_idx_nxt;
         r_step  <= w_step_nxt;
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_result <= DICE_MIN;
         r_valid  <= 1'b0;
         r_error  <= 1'b0;
      end else if ((r_state == IDLE) && w_rise) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_result <= DiceValue;
         r_valid  <= 1'b1;
         if ((DiceValue < DICE_MIN) || (DiceValue > DICE_MAX)) r_error <= 1'b1;
      end
   end

   assign w_lfsr_unused = ^w_lfsr[15:2];

   assign Ran         = w_lfsr[1:0];
   assign Step        = r_step;
   assign Busy        = (r_state != IDLE);
   assign Result      = r_result;
   assign ResultValid = r_valid;
   assign Error       = r_error;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: schedule-based roll model with per-cycle compare plus literal pins.
`timescale 1ns/1ps
module tb_dice_roll_ctrl;

   localparam int          SPIN_MIN   = 8;
   localparam int          SLOW_STEPS = 3;
   localparam int          HOLDOFF    = 4;
   localparam logic [15:0] SEED       = 16'hACE1;

   logic       Clock  = 1'b0;
   logic       nReset = 1'b0;
   logic       Roll   = 1'b0;
   logic [2:0] DiceValue;
   logic [1:0] Ran;
   logic       Step, Busy, ResultValid, Error;
   logic [2:0] Result;

   int n_checks = 0;
   int n_errors = 0;

   logic       force7 = 1'b0;
   logic [2:0] face;

   always #5 Clock = ~Clock;

   dice_roll_ctrl #(
      .SPIN_MIN   (SPIN_MIN),
      .SLOW_STEPS (SLOW_STEPS),
      .HOLDOFF    (HOLDOFF),
      .LFSR_SEED  (SEED)
   ) u_dut (
      .Clock       (Clock),
      .nReset      (nReset),
      .Roll        (Roll),
      .DiceValue   (DiceValue),
      .Ran         (Ran),
      .Step        (Step),
      .Busy        (Busy),
      .Result      (Result),
      .ResultValid (ResultValid),
      .Error       (Error)
   );

   // Stand-in dice core: advances 1..6 on every cycle the DUT asserts Step.
   always @(posedge Clock or negedge nReset) begin
      if (!nReset)   face <= 3'd1;
      else if (Step) face <= (face == 3'd6) ? 3'd1 : face + 3'd1;
   end
   assign DiceValue = force7 ? 3'd7 : face;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
      logic out_bit;
      out_bit = s[0];
      s = s >> 1;
      if (out_bit) s = s ^ 16'hB400;
      return s;
   endfunction

   // Model: a roll is a spin of data-dependent length followed by a fixed, precomputed
   // schedule of (step, busy, capture) cycles.
   typedef struct packed {
      logic step;
      logic busy;
      logic cap;
   } cyc_t;

   cyc_t        sched[$];
   cyc_t        cur = '0;
   int          mode = 0;   // 0 idle, 1 spinning, 2 playing schedule
   int          spin_n = 0;
   int          m_steps = 0;
   logic        h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
   logic        m_s1, m_rise;
   logic [2:0]  m_res = 3'd1;
   logic        m_rv = 1'b0, m_err = 1'b0;
   logic [15:0] m_lfsr = SEED;

   always @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         mode = 0; spin_n = 0; m_steps = 0;
         h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
         m_res = 3'd1; m_rv = 1'b0; m_err = 1'b0;
         m_lfsr = SEED;
         sched.delete();
         cur = '0;
      end else begin
         m_lfsr = ref_lfsr(m_lfsr);
         m_s1   = h2;
         m_rise = h2 && !h3;
         if (cur.step) m_steps++;
         if (cur.cap) begin
            m_res = force7 ? 3'd7 : 3'((m_steps % 6) + 1);
            m_rv  = 1'b1;
            if (m_res > 3'd6) m_err = 1'b1;
         end
         case (mode)
            0: if (m_rise) begin
                  mode = 1; spin_n = 0; m_rv = 1'b0;
               end
            1: begin
                  spin_n++;
                  if (spin_n >= SPIN_MIN && !m_s1) begin
                     for (int i = 0; i < SLOW_STEPS; i++) begin
                        for (int g = 0; g < (2 << i); g++) sched.push_back(cyc_t'{1'b0, 1'b1, 1'b0});
                        sched.push_back(cyc_t'{1'b1, 1'b1, 1'b0});
                     end
                     sched.push_back(cyc_t'{1'b0, 1'b1, 1'b1});
                     for (int j = 0; j < HOLDOFF; j++) sched.push_back(cyc_t'{1'b0, 1'b1, 1'b0});
                     mode = 2;
                  end
               end
            default: begin
                  void'(sched.pop_front());
                  if (sched.size() == 0) mode = 0;
               end
         endcase
         h3 = h2; h2 = h1; h1 = Roll;
         if (mode == 1)      cur = cyc_t'{1'b1, 1'b1, 1'b0};
         else if (mode == 2) cur = sched[0];
         else                cur = '0;
      end
   end

   always @(negedge Clock) begin
      if (nReset) begin
         check("step",  16'(Step),        16'(cur.step));
         check("busy",  16'(Busy),        16'(cur.busy));
         check("result",16'(Result),      16'(m_res));
         check("valid", 16'(ResultValid), 16'(m_rv));
         check("error", 16'(Error),       16'(m_err));
         check("ran",   16'(Ran),         16'(m_lfsr[1:0]));
      end
   end

   // Drive one roll from a negedge; Roll is high for t < hold and at pulse offsets p1/p2.
   task automatic roll_run(input int hold, input int p1, input int p2,
                           output int nsteps, output int nbusy);
      bit seen;
      seen = 1'b0; nsteps = 0; nbusy = 0;
      for (int t = 0; t < 400; t++) begin
         @(negedge Clock);
         if (t > 0) begin
            if (Step) nsteps++;
            if (Busy) begin
               nbusy++;
               seen = 1'b1;
            end else if (seen) begin
               Roll = 1'b0;
               return;
            end
         end
         Roll = (t < hold) || (t == p1) || (t == p2);
      end
      Roll = 1'b0;
      n_checks++;
      n_errors++;
      $display("FAIL roll_timeout: busy_seen %0d, required completed roll within 400 cycles", seen);
   endtask

   initial begin
      int  ns, nb;
      bit  zero_seen, early;
      logic [15:0] s;

      repeat (3) @(negedge Clock);
      check("rst_step",   16'(Step),        16'd0);
      check("rst_busy",   16'(Busy),        16'd0);
      check("rst_result", 16'(Result),      16'd1);
      check("rst_valid",  16'(ResultValid), 16'd0);
      check("rst_error",  16'(Error),       16'd0);
      check("rst_ran",    16'(Ran),         16'd1);

      s = ref_lfsr(16'hACE1);
      check("ref_lfsr_1", s, 16'hE270);
      s = ref_lfsr(ref_lfsr(ref_lfsr(s)));
      check("ref_lfsr_4", s, 16'h1C4E);

      nReset = 1'b1;
      repeat (4) @(negedge Clock);
      check("ran_after4", 16'(Ran), 16'd2);

      roll_run(1, -1, -1, ns, nb);
      check("short_steps", 16'(ns), 16'd11);
      check("short_busy",  16'(nb), 16'd30);
      check("short_result",16'(Result), 16'd6);
      check("short_valid", 16'(ResultValid), 16'd1);
      repeat (3) @(negedge Clock);

      roll_run(20, -1, -1, ns, nb);
      check("held_steps",  16'(ns), 16'd23);
      check("held_busy",   16'(nb), 16'd42);
      check("held_result", 16'(Result), 16'd5);
      repeat (3) @(negedge Clock);

      roll_run(1, 14, 27, ns, nb);
      check("ignored_steps", 16'(ns), 16'd11);
      check("ignored_busy",  16'(nb), 16'd30);
      repeat (3) @(negedge Clock);

      roll_run(1, -1, -1, ns, nb);
      check("again_steps", 16'(ns), 16'd11);
      repeat (3) @(negedge Clock);

      force7 = 1'b1;
      roll_run(1, -1, -1, ns, nb);
      force7 = 1'b0;
      check("bad_result", 16'(Result), 16'd7);
      check("bad_error",  16'(Error),  16'd1);
      repeat (3) @(negedge Clock);

      roll_run(1, -1, -1, ns, nb);
      check("sticky_error", 16'(Error),  16'd1);
      check("good_result",  16'(Result), 16'd1);
      repeat (3) @(negedge Clock);

      Roll = 1'b1;
      @(negedge Clock);
      Roll = 1'b0;
      repeat (4) @(negedge Clock);
      check("spin_busy", 16'(Busy), 16'd1);
      check("spin_step", 16'(Step), 16'd1);
      #2 nReset = 1'b0;
      #1;
      check("async_step",   16'(Step),        16'd0);
      check("async_busy",   16'(Busy),        16'd0);
      check("async_valid",  16'(ResultValid), 16'd0);
      check("async_error",  16'(Error),       16'd0);
      check("async_result", 16'(Result),      16'd1);
      check("async_ran",    16'(Ran),         16'd1);

      @(negedge Clock);
      nReset = 1'b1;
      zero_seen = 1'b0;
      early = 1'b0;
      for (int i = 1; i <= 65535; i++) begin
         @(posedge Clock);
         #1;
         if (u_dut.w_lfsr == 16'h0000) zero_seen = 1'b1;
         if (i < 65535 && u_dut.w_lfsr == SEED) early = 1'b1;
         if (i == 3) check("idle_after_reset", 16'(Busy), 16'd0);
      end
      check("lfsr_period",   u_dut.w_lfsr, SEED);
      check("model_period",  m_lfsr,       SEED);
      check("lfsr_nonzero",  16'(zero_seen), 16'd0);
      check("lfsr_no_early", 16'(early),     16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
